// File: rtl/prewish_pkg.sv
// Shared widths and output-FSM encoding for the mask responder.
package prewish_pkg;
  localparam int MASK_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PULSE = 2'b01,
    GAP   = 2'b10
  } state_e;
endpackage

// File: rtl/prewish_mask_fifo.sv
// Small mask FIFO; level is wr-rd with one extra pointer bit, pushes while full are ignored.
module prewish_mask_fifo
  import prewish_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [MASK_W-1:0]     din,
  output logic [MASK_W-1:0]     dout,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  logic [MASK_W-1:0] mem_q [DEPTH];
  logic [MASK_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              push_ok, pop_ok;

  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == PW'(DEPTH));
  assign dout  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & (level != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[DEPTH_LOG2-1:0]] = din;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
endmodule

// File: rtl/prewish_mask_responder.sv
// Captures masks on STB_I rising edges into a FIFO and replays them as rate-limited STB_O strobes.
// Edge->STB_O is 3 cycles when idle; strobes are spaced 2**GAP_BITS+1 cycles; a full queue drops with ERR_O.
module prewish_mask_responder
  import prewish_pkg::*;
#(
  parameter int GAP_BITS   = 4,
  parameter int DEPTH_LOG2 = 2,
  parameter int ALIVE_BITS = 23
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic                STB_I,
  input  logic [MASK_W-1:0]   DAT_I,
  output logic                ACK_O,
  output logic                ERR_O,
  output logic                STB_O,
  output logic [MASK_W-1:0]   DAT_O,
  output logic [DEPTH_LOG2:0] o_level,
  output logic                o_overflow,
  output logic                o_alive
);
  // PULSE plus the GAP cycles plus the IDLE pop cycle gives the 2**GAP_BITS+1 period.
  localparam logic [GAP_BITS-1:0] GAP_MAX = GAP_BITS'((1 << GAP_BITS) - 2);

  logic                  stb_prev_q, stb_prev_d;
  logic                  edge_q, edge_d;
  logic [MASK_W-1:0]     din_q, din_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  ovf_q, ovf_d;
  logic [ALIVE_BITS-1:0] alive_q, alive_d;
  state_e                state_q, state_d;
  logic [GAP_BITS-1:0]   gap_cnt_q, gap_cnt_d;
  logic                  stb_o_q, stb_o_d;
  logic [MASK_W-1:0]     dat_o_q, dat_o_d;

  logic                  fifo_push, fifo_pop, fifo_full;
  logic [MASK_W-1:0]     fifo_dout;
  logic [DEPTH_LOG2:0]   fifo_level;

  prewish_mask_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk   (CLK_I),
    .rst_n (RST_I),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (din_q),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full)
  );

  always_comb begin
    stb_prev_d = STB_I;
    edge_d     = STB_I & ~stb_prev_q;
    din_d      = edge_d ? DAT_I : din_q;
    fifo_push  = edge_q & ~fifo_full;
    ack_d      = fifo_push;
    err_d      = edge_q & fifo_full;
    ovf_d      = ovf_q | err_d;
    alive_d    = alive_q + ALIVE_BITS'(1);

    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    stb_o_d    = 1'b0;
    dat_o_d    = dat_o_q;
    fifo_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_level != '0) begin
          fifo_pop = 1'b1;
          dat_o_d  = fifo_dout;
          stb_o_d  = 1'b1;
          state_d  = PULSE;
        end
      end
      PULSE: begin
        state_d   = GAP;
        gap_cnt_d = '0;
      end
      GAP: begin
        if (gap_cnt_q == GAP_MAX) begin
          state_d   = IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_BITS'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        gap_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      stb_prev_q <= 1'b0;
      edge_q     <= 1'b0;
      din_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      alive_q    <= '0;
    end else begin
      stb_prev_q <= stb_prev_d;
      edge_q     <= edge_d;
      din_q      <= din_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      alive_q    <= alive_d;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q   <= IDLE;
      gap_cnt_q <= '0;
      stb_o_q   <= 1'b0;
      dat_o_q   <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      stb_o_q   <= stb_o_d;
      dat_o_q   <= dat_o_d;
    end
  end

  assign ACK_O      = ack_q;
  assign ERR_O      = err_q;
  assign STB_O      = stb_o_q;
  assign DAT_O      = dat_o_q;
  assign o_level    = fifo_level;
  assign o_overflow = ovf_q;
  assign o_alive    = alive_q[ALIVE_BITS-1];
endmodule

// File: tb/tb_prewish_mask_responder.sv
// Scoreboard bench: a timestamp model predicts accept/drop and strobe times; a monitor compares every cycle.
module tb_prewish_mask_responder;
  localparam int GAPB   = 4;
  localparam int PERIOD = (1 << GAPB) + 1;
  localparam int DEPTH  = 4;
  localparam int NEVER  = 32'h7fff_ffff;

  logic       CLK_I = 1'b0;
  logic       RST_I = 1'b0;
  logic       STB_I = 1'b0;
  logic [7:0] DAT_I = 8'h00;
  logic       ACK_O, ERR_O, STB_O, o_overflow, o_alive;
  logic [7:0] DAT_O;
  logic [2:0] o_level;

  prewish_mask_responder #(.GAP_BITS(GAPB), .DEPTH_LOG2(2), .ALIVE_BITS(3)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .STB_I(STB_I), .DAT_I(DAT_I),
    .ACK_O(ACK_O), .ERR_O(ERR_O), .STB_O(STB_O), .DAT_O(DAT_O),
    .o_level(o_level), .o_overflow(o_overflow), .o_alive(o_alive)
  );

  always #5 CLK_I = ~CLK_I;

  int vectors = 0;
  int miscompares = 0;

  typedef struct { bit is_err; int t; } resp_t;
  typedef struct { logic [7:0] dat; int t; } emit_t;

  // Model state: cycle index since reset release, accepted items' push/pop timestamps.
  int    cyc;
  bit    stb_prev;
  int    push_t[$];
  int    pop_t[$];
  int    last_pop;
  int    ovf_t;
  int    occ;
  int    p;
  resp_t exp_resp[$];
  emit_t exp_emit[$];

  int         ack_cnt = 0, err_cnt = 0, stb_cnt = 0;
  logic [7:0] exp_dat;
  int         lvl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  // Reference model: rising edges become accept/drop decisions with predicted timestamps.
  always @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      cyc = 0; stb_prev = 0; last_pop = -1000; ovf_t = NEVER;
      push_t.delete(); pop_t.delete(); exp_resp.delete(); exp_emit.delete();
    end else begin
      cyc++;
      while (pop_t.size() > 0 && pop_t[0] < cyc) begin
        void'(pop_t.pop_front());
        void'(push_t.pop_front());
      end
      if (STB_I && !stb_prev) begin
        occ = 0;
        foreach (pop_t[i]) if (pop_t[i] > cyc) occ++;
        if (occ >= DEPTH) begin
          exp_resp.push_back('{1'b1, cyc + 1});
          if (ovf_t == NEVER) ovf_t = cyc + 1;
        end else begin
          p = (cyc + 2 > last_pop + PERIOD) ? cyc + 2 : last_pop + PERIOD;
          last_pop = p;
          push_t.push_back(cyc + 1);
          pop_t.push_back(p);
          exp_resp.push_back('{1'b0, cyc + 1});
          exp_emit.push_back('{DAT_I, p});
        end
      end
      stb_prev = STB_I;
    end
  end

  // Monitor: sampled on the falling edge, pops due expectations and compares.
  always @(negedge CLK_I) begin
    if (!RST_I) begin
      exp_dat = 8'h00;
      check("rst_outputs", {19'd0, ACK_O, ERR_O, STB_O, DAT_O, o_level, o_overflow, o_alive}, 32'd0);
    end else begin
      bit due_r, due_e, r_err;
      due_r = (exp_resp.size() > 0) && (exp_resp[0].t == cyc);
      due_e = (exp_emit.size() > 0) && (exp_emit[0].t == cyc);
      r_err = due_r ? exp_resp[0].is_err : 1'b0;
      if (ACK_O) ack_cnt++;
      if (ERR_O) err_cnt++;
      if (STB_O) stb_cnt++;
      if (due_r || ACK_O || ERR_O) begin
        check("ack_o", 32'(ACK_O), 32'(due_r && !r_err));
        check("err_o", 32'(ERR_O), 32'(due_r && r_err));
      end
      if (due_r) void'(exp_resp.pop_front());
      if (due_e || STB_O) check("stb_o", 32'(STB_O), 32'(due_e));
      if (due_e) begin
        exp_dat = exp_emit[0].dat;
        void'(exp_emit.pop_front());
      end
      check("dat_o", 32'(DAT_O), 32'(exp_dat));
      lvl = 0;
      foreach (push_t[i]) if (push_t[i] <= cyc && pop_t[i] > cyc) lvl++;
      check("o_level", 32'(o_level), 32'(lvl));
      check("o_overflow", 32'(o_overflow), 32'(cyc >= ovf_t));
      check("o_alive", 32'(o_alive), 32'((cyc >> 2) & 1));
    end
  end

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic pulse(input logic [7:0] d, input int len);
    STB_I = 1'b1; DAT_I = d;
    repeat (len) tick();
    STB_I = 1'b0;
  endtask

  task automatic do_reset(input bit stb_at_release);
    RST_I = 1'b0;
    #1;
    check("rst_now_stb_o", 32'(STB_O), 32'd0);
    check("rst_now_dat_o", 32'(DAT_O), 32'd0);
    check("rst_now_level", 32'(o_level), 32'd0);
    check("rst_now_misc", {28'd0, ACK_O, ERR_O, o_overflow, o_alive}, 32'd0);
    tick(); tick();
    STB_I = stb_at_release;
    RST_I = 1'b1;
  endtask

  int a0, e0, s0;

  initial begin
    repeat (3) tick();
    RST_I = 1'b1;
    repeat (5) tick();

    // Single strobe.
    a0 = ack_cnt; s0 = stb_cnt;
    pulse(8'hA8, 1);
    repeat (30) tick();
    check("single_acks", 32'(ack_cnt - a0), 32'd1);
    check("single_stbs", 32'(stb_cnt - s0), 32'd1);

    // Long strobe: one capture only.
    a0 = ack_cnt; s0 = stb_cnt;
    pulse(8'hCA, 800);
    repeat (30) tick();
    check("long_acks", 32'(ack_cnt - a0), 32'd1);
    check("long_stbs", 32'(stb_cnt - s0), 32'd1);

    // Overflow: six edges two cycles apart.
    a0 = ack_cnt; e0 = err_cnt; s0 = stb_cnt;
    for (int i = 1; i <= 6; i++) begin
      pulse(8'(i), 1);
      tick();
    end
    repeat (100) tick();
    check("ovf_acks", 32'(ack_cnt - a0), 32'd5);
    check("ovf_errs", 32'(err_cnt - e0), 32'd1);
    check("ovf_stbs", 32'(stb_cnt - s0), 32'd5);
    check("ovf_flag", 32'(o_overflow), 32'd1);
    do_reset(1'b0);
    repeat (5) tick();

    // Push lands on the same cycle as the pop with one item queued.
    pulse(8'h11, 1); tick();
    pulse(8'h22, 1); repeat (15) tick();
    pulse(8'h33, 1);
    repeat (60) tick();

    // Reset mid-GAP with three masks queued.
    for (int i = 0; i < 4; i++) begin
      pulse(8'h40 + 8'(i), 1);
      tick();
    end
    repeat (4) tick();
    #2;
    s0 = stb_cnt;
    do_reset(1'b0);
    repeat (50) tick();
    check("post_rst_stbs", 32'(stb_cnt - s0), 32'd0);

    // STB_I already high as reset releases.
    do_reset(1'b1);
    DAT_I = 8'h5D;
    repeat (3) tick();
    STB_I = 1'b0;
    repeat (25) tick();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 799) == 0) do_reset(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) STB_I = ~STB_I;
      DAT_I = 8'($urandom);
      tick();
    end

    STB_I = 1'b0;
    for (int k = 0; k < 200 && (exp_emit.size() > 0 || exp_resp.size() > 0); k++) tick();
    check("drain_pending", 32'(exp_emit.size() + exp_resp.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
